// File: rtl/div_sequencer_if.sv
// ============================================================================
// Module  : div_sequencer_if
// Purpose : EX-stage request/response bundle for the iterative divide unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface div_sequencer_if #(
  parameter int XLEN = 32
);
  logic            DivReqE;
  logic [1:0]      DivOpE;
  logic [XLEN-1:0] Operand1E;
  logic [XLEN-1:0] Operand2E;
  logic            FlushE;
  logic            DivBusyE;
  logic            DivDoneE;
  logic [XLEN-1:0] DivResultE;

  modport master (
    output DivReqE, DivOpE, Operand1E, Operand2E, FlushE,
    input  DivBusyE, DivDoneE, DivResultE
  );

  modport slave (
    input  DivReqE, DivOpE, Operand1E, Operand2E, FlushE,
    output DivBusyE, DivDoneE, DivResultE
  );
endinterface

`default_nettype wire

// File: rtl/div_sequencer.sv
// ============================================================================
// Module  : div_sequencer
// Purpose : RV32M DIV/DIVU/REM/REMU sequencer, 32-step restoring division.
//           Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed
//           overflow skip the iteration phase.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_sequencer #(
  parameter int XLEN = 32
) (
  input  wire logic       CPU_CLK,
  input  wire logic       CPU_RSTN,
  div_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [4:0]      count;
  logic [1:0]      op;
  logic            sign1;
  logic            sign2;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] result;

  logic            in_signed;
  logic            in_neg1;
  logic            in_neg2;
  logic            in_zero;
  logic            in_ovf;
  logic [XLEN-1:0] in_abs1;
  logic [XLEN-1:0] in_abs2;

  // DIV and REM (op bit 0 clear) are the signed flavours.
  assign in_signed = ~bus.DivOpE[0];
  assign in_neg1   = in_signed & bus.Operand1E[XLEN-1];
  assign in_neg2   = in_signed & bus.Operand2E[XLEN-1];
  assign in_abs1   = in_neg1 ? -bus.Operand1E : bus.Operand1E;
  assign in_abs2   = in_neg2 ? -bus.Operand2E : bus.Operand2E;
  assign in_zero   = (bus.Operand2E == '0);
  assign in_ovf    = in_signed & (bus.Operand1E == MIN_NEG) &
                     (bus.Operand2E == ALL_ONES);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  assign shifted = {rem, quot[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};

  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] sel_fix;

  always_comb begin
    q_fix = (~op[0] & (sign1 ^ sign2)) ? -quot : quot;
    r_fix = (~op[0] & sign1) ? -rem : rem;
    if (div_zero) begin
      q_fix = ALL_ONES;
      r_fix = dividend;
    end else if (ovf) begin
      q_fix = MIN_NEG;
      r_fix = '0;
    end
    sel_fix = op[1] ? r_fix : q_fix;
  end

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RSTN) begin
      state    <= ST_IDLE;
      count    <= 5'd0;
      result   <= '0;
      op       <= 2'b00;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      quot     <= '0;
    end else if (bus.FlushE) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.DivReqE) begin
            op       <= bus.DivOpE;
            sign1    <= in_neg1;
            sign2    <= in_neg2;
            div_zero <= in_zero;
            ovf      <= in_ovf;
            dividend <= bus.Operand1E;
            divisor  <= in_abs2;
            rem      <= '0;
            quot     <= in_abs1;
            count    <= 5'd31;
`ifdef DIV_EARLY_OUT_EN
            state    <= (in_zero | in_ovf) ? ST_FIX : ST_ITER;
`else
            state    <= ST_ITER;
`endif
          end
        end
        ST_ITER: begin
          // Keep the trial difference only when it did not borrow.
          if (!diff[XLEN]) begin
            rem  <= diff[XLEN-1:0];
            quot <= {quot[XLEN-2:0], 1'b1};
          end else begin
            rem  <= shifted[XLEN-1:0];
            quot <= {quot[XLEN-2:0], 1'b0};
          end
          if (count == 5'd0) begin
            state <= ST_FIX;
          end else begin
            count <= count - 5'd1;
          end
        end
        ST_FIX: begin
          result <= sel_fix;
          state  <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  logic busy;

  always_comb begin
    busy = 1'b0;
    case (state)
      ST_IDLE: busy = bus.DivReqE;
      ST_ITER: busy = 1'b1;
      ST_FIX:  busy = 1'b1;
      default: busy = 1'b0;
    endcase
    if (!CPU_RSTN || bus.FlushE) begin
      busy = 1'b0;
    end
  end

  assign bus.DivBusyE   = busy;
  assign bus.DivDoneE   = CPU_RSTN & ~bus.FlushE & (state == ST_DONE);
  assign bus.DivResultE = result;

endmodule

`default_nettype wire

// File: doc/div_sequencer.md
# div_sequencer

Iterative RV32M divide/remainder unit for the EX stage of the pipelined core. It accepts one DIV/DIVU/REM/REMU operation from EX, runs a 32-iteration restoring division, and holds the pipeline through a stall request to the hazard logic. It returns the result with a one-cycle done pulse. Decode of the M-extension opcode happens upstream; this block only sequences the divider datapath.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `CPU_CLK` input 1: the single clock; all state updates on the rising edge.
- `CPU_RSTN` input 1: synchronous, active-low reset.
- `DivReqE` input 1: a divide op is valid in EX.
- `DivOpE` input 2: operation select; 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `Operand1E` input 32: dividend (rs1).
- `Operand2E` input 32: divisor (rs2).
- `FlushE` input 1: kill the EX-stage op; aborts any operation in progress.
- `DivBusyE` output 1: stall request to the hazard unit.
- `DivDoneE` output 1: one-cycle pulse; `DivResultE` is valid.
- `DivResultE` output 32: quotient or remainder, registered.

## Operation
- States: IDLE, ITER, FIX, DONE.
- **IDLE**
  - `DivReqE=1` and `FlushE=0` latches the opcode, the operand signs, and abs(Operand1E)/abs(Operand2E). Absolute values apply only to DIV/REM.
  - Next state is ITER with iteration counter = 31.
- **ITER**
  - One restoring step per cycle: shift {rem,quot} left by 1, trial-subtract the divisor, keep the difference if it is non-negative and set quot bit 0.
  - Counter decrements each cycle; when the counter is 0, next state is FIX.
- **FIX**
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - Special cases are forced here:
    - divisor 0: quotient 0xFFFFFFFF, remainder = original dividend.
    - DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - The selected result is written into `DivResultE`; next state is DONE.
- **DONE**
  - `DivDoneE=1`; `DivReqE` is ignored this cycle.
  - Next state is always IDLE.
- `DivBusyE` is combinational:
  - equals `DivReqE & ~FlushE` in IDLE;
  - is 1 in ITER and FIX;
  - is 0 in DONE.
  - The pipeline holds EX while it is high and advances on the DONE cycle.
- `FlushE=1` in any state: next state is IDLE, `DivResultE` is unchanged, and no done pulse occurs. `DivBusyE` is 0 in the flush cycle in every state.
- `DivResultE` holds its last value until the next FIX.
- Reset values: state IDLE, counter 0, `DivResultE`=0, `DivDoneE`=0. `DivBusyE`=0 while `CPU_RSTN`=0, regardless of `DivReqE`.
- Reset mid-operation returns to IDLE at that edge; the partial result is discarded.

## Timing
- Request sampled in IDLE at cycle N: ITER runs cycles N+1..N+32, FIX is N+33, DONE is N+34. `DivDoneE` and a valid `DivResultE` appear in cycle N+34.
- Latency is 34 cycles; `DivBusyE` is high for cycles N..N+33.
- Back-to-back: the next divide advances into EX at N+35. It is sampled in IDLE that cycle, so there is no extra bubble beyond DONE.
- Flush at cycle F: state is IDLE at F+1, and a new request can be sampled at F+1.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - A zero divisor or signed overflow detected in IDLE goes directly to FIX, skipping ITER.
  - Done at N+2; `DivBusyE` is high for N..N+1.
- Undefined: these cases run the full 34-cycle sequence.
- Result values are identical either way.

## Test plan
- DIVU 100/7 requested at cycle 0: `DivBusyE` high for cycles 0–33, `DivDoneE` pulse at cycle 34 with `DivResultE`=14. REMU on the same operands gives 2.
- REM 0xFFFFFFF9 (−7) / 2: result 0xFFFFFFFF. DIV on the same operands gives 0xFFFFFFFD (−3).
- DIV 5/0: result 0xFFFFFFFF; REMU 5/0: result 5. With `DIV_EARLY_OUT_EN`, done at cycle 2; without it, done at cycle 34.
- DIV 0x80000000 / 0xFFFFFFFF: result 0x80000000. REM on the same operands gives 0.
- `FlushE` at iteration cycle 10: busy low that cycle, no done pulse. A DIVU 9/3 request at cycle 11 gives done at cycle 45 with result 3, and the prior `DivResultE` is unchanged until then.
- `CPU_RSTN` low at cycle 20 mid-divide: state IDLE, `DivResultE`=0, busy/done 0. The first request after release completes 34 cycles later.
